tungsten_spi_rx: RTL and testbench
==================================

# tungsten_spi_rx

Host-side SPI (mode 0) receive front-end for the tungsten core. Three pins from `ui_in` are synchronised into the core clock domain, deserialised into bytes, and buffered in a small FIFO. The core drains the FIFO through a valid/ready handshake, so program and data bytes reach it without pin-level timing concerns.

## Interface
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥2.
- `clk` input 1: core clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset. The core clock is the only clock.
- `spi_sclk` input 1: SPI clock from the pin. Asynchronous to `clk`.
- `spi_cs_n` input 1: chip select from the pin, active low. Asynchronous to `clk`.
- `spi_mosi` input 1: serial data from the pin. Asynchronous to `clk`.
- `out_data` output 8: byte at the FIFO head.
- `out_valid` output 1: FIFO is non-empty.
- `out_ready` input 1: core accepts `out_data` this cycle.
- `level` output $clog2(DEPTH)+1: number of occupied FIFO entries.
- `overflow` output 1: sticky flag, set when a completed byte was dropped.
- `ovf_clr` input 1: synchronous clear of `overflow`.

## Operation
- **Synchronisers.** Each of `spi_sclk`, `spi_cs_n` and `spi_mosi` passes through a 2-flop synchroniser. A third flop on `sclk` supports edge detection. Reset values: sclk chain 0, cs_n chain 1, mosi chain 0.
- **Bit sampling.** `rise` is true when synced sclk is 1 and the delayed sclk is 0. On `rise` with synced cs_n low, shift synced mosi into an 8-bit shift register MSB-first (shift left, new bit into [0]) and increment a 3-bit bit counter.
- **Byte complete.** When the counter wraps 7→0, the completed byte (the shift value with the new bit included) raises a 1-cycle push request.
- **Deselect.** While synced cs_n is 1, the bit counter is held at 0. A partial byte is discarded, with no push and no flag. The shift register contents are don't-care.
- **FIFO.** DEPTH×8 storage with read pointer, write pointer and `level`. Pointers wrap modulo DEPTH.
  - Pop occurs when `out_valid && out_ready`.
  - Push is accepted when `level < DEPTH`, or when a pop happens in the same cycle.
  - If the FIFO is full with no pop, the byte is dropped and `overflow` is set.
- **Same-cycle events.**
  - Push and pop together: `level` is unchanged and both pointers advance.
  - Push and pop together while full: the push is accepted and `overflow` is not set.
  - `ovf_clr` and a new overflow in the same cycle: set wins.
- **Outputs.**
  - `out_data` = `mem[rd_ptr]`. Its value is don't-care when `out_valid` = 0.
  - `out_valid` = (`level` != 0).
- **Reset values.** On `rst`: pointers 0, `level` 0, bit counter 0, `out_valid` 0, `overflow` 0, `out_data` 0. Memory contents are not reset. Reset mid-byte discards the byte.

## Timing
- A pin sclk rise first captured at clk edge N is shifted at edge N+2.
- For the 8th bit, the FIFO write and `level` increment happen at edge N+3. `out_valid` is high after edge N+3, i.e. 3–4 clk periods of pin-to-valid latency.
- Pop takes effect at the edge where `out_valid && out_ready`. The next entry, or `out_valid` = 0, is visible after that edge.
- Throughput is one pop per cycle.
- Legal SPI timing:
  - sclk high ≥3 clk periods and low ≥3 clk periods.
  - mosi stable from 3 clk periods before the sclk rise until 1 clk period after it.
  - cs_n falls ≥3 clk periods before the first sclk rise.
  Violations give undefined data but never corrupt the FIFO pointers.

## Configuration
- `TUNGSTEN_SPI_LSB_FIRST_EN`: defined selects LSB-first reception (shift right, new bit into [7]). Undefined (default) selects MSB-first. Framing, FIFO behaviour and latency are identical in both modes.

## Test plan
- **Reset:** assert `rst` mid-byte, then release. Required: `out_valid` = 0, `level` = 0, `overflow` = 0. Then send 0xA5 with out_ready = 0 → `out_data` = 0xA5, `level` = 1, reached within 4 clk periods of the 8th sclk rise.
- **Partial byte:** send 5 bits of 0xFF, raise cs_n, lower it again, send 0x3C → exactly one byte, 0x3C, is received.
- **Fill and overflow:** with DEPTH = 4 and out_ready = 0, send 0x01..0x05 → `level` = 4, `overflow` = 1. Draining yields 0x01..0x04. Pulsing `ovf_clr` then gives `overflow` = 0.
- **Push and pop while full:** FIFO full, and out_ready pulsed in exactly the push cycle of a 5th byte 0x77 → `level` stays 4, `overflow` = 0. Draining yields 0x02, 0x03, 0x04, 0x77.
- **Back-to-back stream:** 16 bytes 0x00..0x0F in one cs_n frame at minimum sclk period, out_ready = 1 → all 16 bytes are received in order with no overflow.
- **Bit-order build:** with `TUNGSTEN_SPI_LSB_FIRST_EN`, pin sequence 1,0,0,0,0,0,0,0 → 0x01. Without the macro, the same sequence → 0x80.

Source files
------------

// File: rtl/tungsten_spi_rx.sv
// SPI mode-0 receive front-end: pin synchronisers, byte deserialiser and a small byte FIFO.
// Optional macro TUNGSTEN_SPI_LSB_FIRST_EN selects LSB-first reception (default MSB-first).
module tungsten_spi_rx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [2:0]    sclk_q, sclk_d;
    logic [1:0]    cs_q, cs_d;
    logic [1:0]    mosi_q, mosi_d;
    logic [7:0]    shift_q, shift_d, shift_new;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          push_q, push_d;
    logic [7:0]    push_data_q, push_data_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          rise, pop, accept;
    logic [7:0]    mem [DEPTH];

    assign sclk_d = {sclk_q[1:0], spi_sclk};
    assign cs_d   = {cs_q[0], spi_cs_n};
    assign mosi_d = {mosi_q[0], spi_mosi};
    assign rise   = sclk_q[1] & ~sclk_q[2];

`ifdef TUNGSTEN_SPI_LSB_FIRST_EN
    assign shift_new = {mosi_q[1], shift_q[7:1]};
`else
    assign shift_new = {shift_q[6:0], mosi_q[1]};
`endif

    // Deserialiser: deselect forces re-framing, the wrap 7->0 marks a full byte.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (cs_q[1]) begin
            bit_cnt_d = 3'd0;
        end else if (rise) begin
            shift_d   = shift_new;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                push_d      = 1'b1;
                push_data_d = shift_new;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        pop        = out_valid & out_ready;
        accept     = push_q & ((level_q < LW'(DEPTH)) | pop);
        rd_ptr_d   = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        level_d    = level_q + LW'(accept) - LW'(pop);
        overflow_d = overflow_q;
        if (push_q && !accept) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= 3'b000;
            cs_q        <= 2'b11;
            mosi_q      <= 2'b00;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= push_data_q;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : 8'h00;
    assign level     = level_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_tungsten_spi_rx.sv
// Directed bench for tungsten_spi_rx; pin bit order follows TUNGSTEN_SPI_LSB_FIRST_EN.
module tb_tungsten_spi_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] level;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    tungsten_spi_rx #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic logic bit_at(input logic [7:0] b, input int i);
`ifdef TUNGSTEN_SPI_LSB_FIRST_EN
        return b[i];
`else
        return b[7-i];
`endif
    endfunction

    // One SPI bit at minimum legal timing: 3 clk low (mosi set), 3 clk high.
    task automatic spi_bit(input logic b);
        spi_mosi = b;
        repeat (3) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (3) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) spi_bit(bit_at(b, i));
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string name);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            miscompares++;
            $display("FAIL %s: valid=%b data=%h required valid=1 data=%h", name, out_valid, out_data, exp);
        end else begin
            $display("pop %s data=%h", name, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_status(input logic [2:0] exp_level, input logic exp_ovf, input string name);
        vectors++;
        if (level !== exp_level || overflow !== exp_ovf || out_valid !== (exp_level != 0)) begin
            miscompares++;
            $display("FAIL %s: level=%0d ovf=%b valid=%b required level=%0d ovf=%b",
                     name, level, overflow, out_valid, exp_level, exp_ovf);
        end else begin
            $display("status %s level=%0d ovf=%b", name, level, overflow);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cs_low();
        send_bits(8'hFF, 3);
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 || out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: valid=%b level=%0d ovf=%b data=%h required 0/0/0/00",
                     out_valid, level, overflow, out_data);
        end else $display("reset_async ok");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_status(3'd0, 1'b0, "reset_release");
        // cs_n stays low: a stale bit count would misalign this byte
        send_bits(8'hA5, 7);
        spi_mosi = bit_at(8'hA5, 7);
        repeat (3) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (3) @(negedge clk);
        check_status(3'd0, 1'b0, "latency_before_write");
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || level !== 3'd1 || out_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL latency_a5: valid=%b level=%0d data=%h required 1/1/a5", out_valid, level, out_data);
        end else $display("latency_a5 data=%h", out_data);
        spi_sclk = 1'b0;
        cs_high();
        pop_expect(8'hA5, "reset_a5");
        check_status(3'd0, 1'b0, "reset_drained");
    endtask

    task automatic test_partial();
        cs_low();
        send_bits(8'hFF, 5);
        cs_high();
        cs_low();
        send_bits(8'h3C, 8);
        cs_high();
        check_status(3'd1, 1'b0, "partial_one_byte");
        pop_expect(8'h3C, "partial_3c");
        check_status(3'd0, 1'b0, "partial_drained");
    endtask

    task automatic test_overflow();
        cs_low();
        for (int i = 1; i <= 5; i++) send_bits(8'(i), 8);
        cs_high();
        check_status(3'd4, 1'b1, "fill_overflow");
        for (int i = 1; i <= 4; i++) pop_expect(8'(i), "fill_drain");
        check_status(3'd0, 1'b1, "ovf_sticky");
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_status(3'd0, 1'b0, "ovf_cleared");
    endtask

    task automatic test_push_pop_full();
        cs_low();
        for (int i = 1; i <= 4; i++) send_bits(8'(i), 8);
        send_bits(8'h77, 7);
        spi_mosi = bit_at(8'h77, 7);
        repeat (3) @(negedge clk);
        spi_sclk = 1'b1;
        // pin rise captured at edge N; FIFO write at N+3, so ready spans that edge only
        repeat (3) @(negedge clk);
        check_status(3'd4, 1'b0, "full_before_push");
        pop_expect(8'h01, "full_pop_01");
        check_status(3'd4, 1'b0, "full_push_pop");
        spi_sclk = 1'b0;
        cs_high();
        pop_expect(8'h02, "full_drain");
        pop_expect(8'h03, "full_drain");
        pop_expect(8'h04, "full_drain");
        pop_expect(8'h77, "full_drain");
        check_status(3'd0, 1'b0, "full_drained");
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        out_ready = 1'b1;
        fork
            begin
                cs_low();
                for (int i = 0; i < 16; i++) send_bits(8'(i), 8);
                cs_high();
            end
            begin
                for (int c = 0; c < 16 * 48 + 40; c++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) begin
                        vectors++;
                        if (out_data !== 8'(idx)) begin
                            miscompares++;
                            $display("FAIL stream_byte: data=%h required %h", out_data, 8'(idx));
                        end else $display("stream byte %0d data=%h", idx, out_data);
                        idx++;
                    end
                end
            end
        join
        out_ready = 1'b0;
        vectors++;
        if (idx != 16 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_count: got=%0d ovf=%b required 16 ovf=0", idx, overflow);
        end else $display("stream count=%0d", idx);
    endtask

    task automatic test_bit_order();
        logic [7:0] exp;
`ifdef TUNGSTEN_SPI_LSB_FIRST_EN
        exp = 8'h01;
`else
        exp = 8'h80;
`endif
        cs_low();
        spi_bit(1'b1);
        for (int i = 0; i < 7; i++) spi_bit(1'b0);
        cs_high();
        check_status(3'd1, 1'b0, "bit_order_level");
        pop_expect(exp, "bit_order");
    endtask

    initial begin
        test_reset();
        test_partial();
        test_overflow();
        test_push_pop_full();
        test_back_to_back();
        test_bit_order();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
